conv_window_addr_gen: RTL and testbench



---
 rtl/cnn_pkg.sv | 37 +++
 rtl/wrap_counter.sv | 45 ++++
 rtl/conv_window_addr_gen.sv | 148 ++++++++++++++
 tb/tb_conv_window_addr_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// cnn_pkg: shared FSM encoding and geometry helpers for the CNN read-address generators.
// Rev 1.0
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Pooled output side; remainders of both divisions are dropped.
    function automatic int out_dim(input int w, input int k, input int s, input int p);
        return ((w - k) / s + 1) / p;
    endfunction

    function automatic int cnt_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Highest address a bank-1 walk can produce must fit in aw bits.
    function automatic bit addr_fits(input int w, input int h, input int k, input int s,
                                     input int p, input int c, input int bank_stride,
                                     input int aw);
        int ow;
        int oh;
        longint max_addr;
        ow = out_dim(w, k, s, p);
        oh = out_dim(h, k, s, p);
        max_addr = longint'(bank_stride) + longint'((c - 1) * w * h)
                 + longint'((s * (p * (oh - 1) + p - 1) + k - 1) * w)
                 + longint'(s * (p * (ow - 1) + p - 1) + k - 1);
        return max_addr < (longint'(1) << aw);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wrap_counter.sv
`default_nettype none
// wrap_counter: modulo-MOD counter with synchronous clear; carry_o fires on an enabled terminal count.
// Rev 1.0
module wrap_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             carry_o
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    assign carry_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (carry_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Exposes the post-update count so a downstream register lines up with this one.
    assign cnt_o = cnt_d;

endmodule
`default_nettype wire

// File: rtl/conv_window_addr_gen.sv
`default_nettype none
// conv_window_addr_gen: walks KxK windows over PxP pool groups, repeats and channels,
// emitting one feature-SRAM read address plus MAC/pool tags per accepted beat. Rev 1.0
module conv_window_addr_gen
    import cnn_pkg::*;
#(
    parameter int W           = 14,
    parameter int H           = 18,
    parameter int K           = 3,
    parameter int S           = 1,
    parameter int P           = 2,
    parameter int C           = 1,
    parameter int NREP        = 1,
    parameter int BANK_STRIDE = 252,
    parameter int AW          = 9
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iSTART,
    input  logic          iBANK,
    input  logic          iREADY,
    output logic [AW-1:0] oADDR,
    output logic          oVLD,
    output logic          oTAP_FIRST,
    output logic          oTAP_LAST,
    output logic          oPOOL_LAST,
    output logic          oBUSY,
    output logic          oDONE
);
    localparam int OW  = out_dim(W, K, S, P);
    localparam int OH  = out_dim(H, K, S, P);
    localparam int XW  = AW + 4;
    localparam int KW  = cnt_width(K);
    localparam int CW  = cnt_width(C);
    localparam int PW  = cnt_width(P);
    localparam int RW  = cnt_width(NREP);
    localparam int OXW = cnt_width(OW);
    localparam int OYW = cnt_width(OH);

    localparam logic [XW-1:0] PLANE = XW'(W * H);
    localparam logic [XW-1:0] ROW   = XW'(W);
    localparam logic [XW-1:0] STR   = XW'(S);
    localparam logic [XW-1:0] POOL  = XW'(P);

    if (OW < 1 || OH < 1) begin : g_empty_map
        $error("conv_window_addr_gen: geometry yields an empty pooled output map");
    end
    if (!addr_fits(W, H, K, S, P, C, BANK_STRIDE, AW)) begin : g_addr_overflow
        $error("conv_window_addr_gen: bank-1 address range exceeds AW bits");
    end

    state_e        state_q, state_d;
    logic [AW-1:0] base_q, base_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          vld_q, first_q, last_q, plast_q, busy_q, done_q;
    logic          first_d, last_d, plast_d;
    logic          start, beat;

    logic [KW-1:0]  kx, ky;
    logic [CW-1:0]  ch;
    logic [PW-1:0]  px, py;
    logic [RW-1:0]  rep_unused;
    logic [OXW-1:0] ox;
    logic [OYW-1:0] oy;
    logic carry_kx, carry_ky, carry_ch, carry_px, carry_py, carry_rep, carry_ox, carry_oy;

    logic [XW-1:0] addr_full;
    logic [3:0]    addr_hi_unused;

    assign start = (state_q == IDLE) & iSTART;
    assign beat  = vld_q & iREADY;

    wrap_counter #(.WIDTH(KW),  .MOD(K))    u_kx  (.clk_i(iCLK), .rst_i(iRST), .en_i(beat),      .clr_i(start), .cnt_o(kx),         .carry_o(carry_kx));
    wrap_counter #(.WIDTH(KW),  .MOD(K))    u_ky  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_kx),  .clr_i(start), .cnt_o(ky),         .carry_o(carry_ky));
    wrap_counter #(.WIDTH(CW),  .MOD(C))    u_ch  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_ky),  .clr_i(start), .cnt_o(ch),         .carry_o(carry_ch));
    wrap_counter #(.WIDTH(PW),  .MOD(P))    u_px  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_ch),  .clr_i(start), .cnt_o(px),         .carry_o(carry_px));
    wrap_counter #(.WIDTH(PW),  .MOD(P))    u_py  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_px),  .clr_i(start), .cnt_o(py),         .carry_o(carry_py));
    wrap_counter #(.WIDTH(RW),  .MOD(NREP)) u_rep (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_py),  .clr_i(start), .cnt_o(rep_unused), .carry_o(carry_rep));
    wrap_counter #(.WIDTH(OXW), .MOD(OW))   u_ox  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_rep), .clr_i(start), .cnt_o(ox),         .carry_o(carry_ox));
    wrap_counter #(.WIDTH(OYW), .MOD(OH))   u_oy  (.clk_i(iCLK), .rst_i(iRST), .en_i(carry_ox),  .clr_i(start), .cnt_o(oy),         .carry_o(carry_oy));

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        case (state_q)
            IDLE: begin
                if (iSTART) begin
                    state_d = RUN;
                    base_d  = iBANK ? AW'(BANK_STRIDE) : '0;
                end
            end
            RUN:     if (carry_oy) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Counters feed in post-update, so the registered outputs describe the beat on the bus.
        addr_full = XW'(base_d) + XW'(ch) * PLANE
                  + (STR * (POOL * XW'(oy) + XW'(py)) + XW'(ky)) * ROW
                  + STR * (POOL * XW'(ox) + XW'(px)) + XW'(kx);
        {addr_hi_unused, addr_d} = addr_full;

        first_d = (kx == '0) & (ky == '0) & (ch == '0);
        last_d  = (kx == KW'(K - 1)) & (ky == KW'(K - 1)) & (ch == CW'(C - 1));
        plast_d = last_d & (px == PW'(P - 1)) & (py == PW'(P - 1));

        if (state_d != RUN) begin
            addr_d  = '0;
            first_d = 1'b0;
            last_d  = 1'b0;
            plast_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            plast_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            vld_q   <= (state_d == RUN);
            first_q <= first_d;
            last_q  <= last_d;
            plast_q <= plast_d;
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign oADDR      = addr_q;
    assign oVLD       = vld_q;
    assign oTAP_FIRST = first_q;
    assign oTAP_LAST  = last_q;
    assign oPOOL_LAST = plast_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_addr_gen.sv
`default_nettype none
// tb_conv_window_addr_gen: scoreboard bench for the default geometry and a C=2/NREP=2/S=2 variant.
// Rev 1.0
`timescale 1ns/1ps
module tb_conv_window_addr_gen;

    typedef struct {
        int addr;
        bit first;
        bit last;
        bit plast;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, a_start, b_start, bank, rdy;
    logic [8:0] a_addr;
    logic [7:0] b_addr;
    logic a_vld, a_tf, a_tl, a_pl, a_busy, a_done;
    logic b_vld, b_tf, b_tl, b_pl, b_busy, b_done;

    conv_window_addr_gen dut_a (
        .iCLK(clk), .iRST(rst), .iSTART(a_start), .iBANK(bank), .iREADY(rdy),
        .oADDR(a_addr), .oVLD(a_vld), .oTAP_FIRST(a_tf), .oTAP_LAST(a_tl),
        .oPOOL_LAST(a_pl), .oBUSY(a_busy), .oDONE(a_done)
    );

    conv_window_addr_gen #(
        .W(7), .H(7), .K(3), .S(2), .P(1), .C(2), .NREP(2), .BANK_STRIDE(98), .AW(8)
    ) dut_b (
        .iCLK(clk), .iRST(rst), .iSTART(b_start), .iBANK(bank), .iREADY(rdy),
        .oADDR(b_addr), .oVLD(b_vld), .oTAP_FIRST(b_tf), .oTAP_LAST(b_tl),
        .oPOOL_LAST(b_pl), .oBUSY(b_busy), .oDONE(b_done)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   log_addr [2048];
    bit   log_last [2048];
    int   nacc  = 0;
    int   ndone = 0;
    bit   use_b = 1'b0;
    bit   rand_rdy = 1'b0;

    int   m_addr;
    logic m_vld, m_tf, m_tl, m_pl, m_busy, m_done;
    assign m_addr = use_b ? int'(b_addr) : int'(a_addr);
    assign m_vld  = use_b ? b_vld  : a_vld;
    assign m_tf   = use_b ? b_tf   : a_tf;
    assign m_tl   = use_b ? b_tl   : a_tl;
    assign m_pl   = use_b ? b_pl   : a_pl;
    assign m_busy = use_b ? b_busy : a_busy;
    assign m_done = use_b ? b_done : a_done;

    // Monitor: every valid cycle is compared against the queue head; pops only on acceptance.
    always @(negedge clk) begin
        if (m_done) ndone++;
        if (m_vld && !rst) begin
            if (q.size() == 0) begin
                if (rdy) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat got addr=%0d required=no beat", m_addr);
                end
            end else begin
                checks++;
                if (m_addr != q[0].addr || m_tf != q[0].first || m_tl != q[0].last || m_pl != q[0].plast) begin
                    errors++;
                    $display("FAIL beat%0d got addr=%0d tf=%0b tl=%0b pl=%0b required addr=%0d tf=%0b tl=%0b pl=%0b",
                             nacc, m_addr, m_tf, m_tl, m_pl, q[0].addr, q[0].first, q[0].last, q[0].plast);
                end
                if (rdy) begin
                    if (nacc < 2048) begin
                        log_addr[nacc] = m_addr;
                        log_last[nacc] = m_tl;
                    end
                    nacc++;
                    void'(q.pop_front());
                end
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) #1 rdy = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model(input int w, input int h, input int k, input int s, input int p,
                         input int c, input int nrep, input int base);
        int ow;
        int oh;
        exp_t e;
        ow = ((w - k) / s + 1) / p;
        oh = ((h - k) / s + 1) / p;
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int r = 0; r < nrep; r++)
                    for (int py = 0; py < p; py++)
                        for (int px = 0; px < p; px++)
                            for (int ch = 0; ch < c; ch++)
                                for (int ky = 0; ky < k; ky++)
                                    for (int kx = 0; kx < k; kx++) begin
                                        e.addr  = base + ch * w * h + (s * (p * oy + py) + ky) * w
                                                + s * (p * ox + px) + kx;
                                        e.first = (kx == 0 && ky == 0 && ch == 0);
                                        e.last  = (kx == k - 1 && ky == k - 1 && ch == c - 1);
                                        e.plast = e.last && px == p - 1 && py == p - 1;
                                        q.push_back(e);
                                    end
    endtask

    task automatic pulse_start(input bit sel_b, input bit bk);
        @(posedge clk);
        #1;
        bank = bk;
        if (sel_b) b_start = 1'b1;
        else       a_start = 1'b1;
        @(posedge clk);
        #1;
        a_start = 1'b0;
        b_start = 1'b0;
    endtask

    // Waits for oDONE, then checks the DONE-cycle and following-cycle handshake.
    task automatic run_to_done(input string name, input int beats, input bit poke_start);
        bit ok;
        int d0;
        ok = 1'b0;
        d0 = ndone;
        for (int i = 0; i < 12000; i++) begin
            if (m_done) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout got=no oDONE required=oDONE within 12000 cycles", name);
        end
        chk({name, "_busy_in_done"}, int'(m_busy), 1);
        if (poke_start) begin
            if (use_b) b_start = 1'b1;
            else       a_start = 1'b1;
        end
        cyc(1);
        a_start = 1'b0;
        b_start = 1'b0;
        chk({name, "_done_width"}, int'(m_done), 0);
        chk({name, "_busy_after"}, int'(m_busy), 0);
        cyc(3);
        chk({name, "_no_restart"}, int'(m_busy), 0);
        chk({name, "_beats"}, nacc, beats);
        chk({name, "_left"}, q.size(), 0);
        chk({name, "_done_pulses"}, ndone - d0, 1);
    endtask

    int t1 [18] = '{0, 1, 2, 14, 15, 16, 28, 29, 30, 1, 2, 3, 15, 16, 17, 29, 30, 31};
    int t4 [18] = '{0, 1, 2, 7, 8, 9, 14, 15, 16, 49, 50, 51, 56, 57, 58, 63, 64, 65};

    initial begin
        int d0;
        bit ok;
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0; bank = 1'b0; rdy = 1'b1;
        cyc(3);
        chk("reset_a_outputs", int'({a_addr, a_vld, a_tf, a_tl, a_pl, a_busy, a_done}), 0);
        chk("reset_b_outputs", int'({b_addr, b_vld, b_tf, b_tl, b_pl, b_busy, b_done}), 0);
        rst = 1'b0;
        cyc(2);

        // Default geometry, bank 0, no stalls.
        q.delete(); nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 0);
        pulse_start(1'b0, 1'b0);
        chk("first_vld_latency", int'(a_vld), 1);
        chk("first_addr", int'(a_addr), 0);
        run_to_done("bank0", 1728, 1'b0);
        for (int i = 0; i < 18; i++) chk($sformatf("bank0_addr%0d", i), log_addr[i], t1[i]);
        chk("bank0_group3_start", log_addr[18], 14);
        chk("bank0_last_addr", log_addr[1727], 251);

        // Bank 1.
        q.delete(); nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 252);
        pulse_start(1'b0, 1'b1);
        run_to_done("bank1", 1728, 1'b0);
        chk("bank1_first_addr", log_addr[0], 252);
        chk("bank1_last_addr", log_addr[1727], 503);

        // Random backpressure; stalled cycles are still compared against the queue head.
        q.delete(); nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 0);
        rand_rdy = 1'b1;
        pulse_start(1'b0, 1'b0);
        run_to_done("stall", 1728, 1'b0);
        rand_rdy = 1'b0;
        cyc(1);
        rdy = 1'b1;

        // Second geometry: C=2, NREP=2, S=2, P=1, 7x7.
        use_b = 1'b1;
        q.delete(); nacc = 0;
        model(7, 7, 3, 2, 1, 2, 2, 0);
        pulse_start(1'b1, 1'b0);
        run_to_done("c2", 324, 1'b0);
        for (int i = 0; i < 18; i++) chk($sformatf("c2_rep0_addr%0d", i), log_addr[i], t4[i]);
        for (int i = 0; i < 18; i++) chk($sformatf("c2_rep1_addr%0d", i), log_addr[18 + i], t4[i]);
        chk("c2_tap_last_65", int'(log_last[17]), 1);
        chk("c2_tap_last_64", int'(log_last[16]), 0);
        use_b = 1'b0;
        cyc(1);

        // Reset at beat 100, then reset with a simultaneous start, then a clean rerun.
        q.delete(); nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 0);
        pulse_start(1'b0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (nacc >= 100) begin
                ok = 1'b1;
                break;
            end
            cyc(1);
        end
        chk("reach_beat100", int'(ok), 1);
        d0 = ndone;
        rst = 1'b1;
        cyc(1);
        chk("midrun_reset_outputs", int'({a_addr, a_vld, a_tf, a_tl, a_pl, a_busy, a_done}), 0);
        a_start = 1'b1;
        cyc(1);
        rst = 1'b0;
        a_start = 1'b0;
        q.delete();
        cyc(4);
        chk("start_with_reset_ignored", int'(a_busy), 0);
        chk("reset_no_done", ndone - d0, 0);
        nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 0);
        pulse_start(1'b0, 1'b0);
        run_to_done("restart", 1728, 1'b0);
        chk("restart_first_addr", log_addr[0], 0);

        // iSTART during RUN and during the DONE cycle.
        q.delete(); nacc = 0;
        model(14, 18, 3, 1, 2, 1, 1, 0);
        pulse_start(1'b0, 1'b0);
        cyc(200);
        a_start = 1'b1;
        cyc(1);
        a_start = 1'b0;
        run_to_done("start_ignored", 1728, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
